rom_rd_arb: RTL and testbench

// - Multi-channel ROM read arbiter/controller; next generation of the single-requester ROM fetch path inside svm_top.
// - Accepts burst read requests from NUM_CH clients, round-robin arbitrates, drives the active-low ROM strobes, returns data per channel.
// - Sits between the SVM datapath clients (weights, support vectors, bias) and the external ROM / rom_model.

---
 rtl/rom_rd_arb.sv | 269 ++++++++++++++++++++++++++
 tb/tb_rom_rd_arb.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_rd_arb.sv
// -----------------------------------------------------------------------------
// rom_rd_arb
// Multi-channel ROM read arbiter/controller. NUM_CH clients post burst read
// requests; a round-robin arbiter picks one client at a time. Each beat of the
// burst is one ROM access: the strobes are driven for one cycle, then the
// controller waits for rom_rd_data_vld and returns the word to the granted
// client.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   req_vld[NUM_CH]     per-channel request valid, held until req_rdy
//   req_addr            per-channel start address, ch i at [i*ADDR_WD +: ADDR_WD]
//   req_len             per-channel burst length minus one, ch i at [i*LEN_WD +: LEN_WD]
//   req_rdy[NUM_CH]     one-hot, single-cycle accept pulse
//   rsp_vld[NUM_CH]     one-hot, data beat valid for that channel
//   rsp_data            shared response data
//   rsp_last            final beat of the burst (qualified by rsp_vld)
//   rsp_err             burst aborted by the watchdog (with rsp_vld, rsp_last)
//   busy                burst in progress
//   rom_rd_addr         ROM address
//   CE_bar, OE_bar      ROM chip/output enable, active low
//   WE_bar              ROM write enable, always 1 (read-only)
//   rom_rd_data         ROM read data
//   rom_rd_data_vld     ROM read data valid strobe
//   state_dbg           current FSM state (IDLE=0, ISSUE=1, WAIT=2)
//
// Handshake: a client raises req_vld[i] with stable req_addr/req_len and
// keeps it up until it sees req_rdy[i] high for one cycle; that cycle is the
// transfer. Responses have no back-pressure: every rsp_vld pulse is one beat
// that the client must take.
//
// Build option: define ROM_TIMEOUT_EN to add a per-beat watchdog that ends the
// burst with rsp_err after TIMEOUT WAIT cycles without rom_rd_data_vld.
// Without it, WAIT holds indefinitely and rsp_err is tied low.
// -----------------------------------------------------------------------------
module rom_rd_arb #(
  parameter int NUM_CH    = 2,
  parameter int ADDR_WD   = 8,
  parameter int DATA_WD   = 8,
  parameter int ROM_DEPTH = 256,
  parameter int LEN_WD    = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_CH-1:0]         req_vld,
  input  logic [NUM_CH*ADDR_WD-1:0] req_addr,
  input  logic [NUM_CH*LEN_WD-1:0]  req_len,
  output logic [NUM_CH-1:0]         req_rdy,
  output logic [NUM_CH-1:0]         rsp_vld,
  output logic [DATA_WD-1:0]        rsp_data,
  output logic                      rsp_last,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [ADDR_WD-1:0]        rom_rd_addr,
  output logic                      CE_bar,
  output logic                      OE_bar,
  output logic                      WE_bar,
  input  logic [DATA_WD-1:0]        rom_rd_data,
  input  logic                      rom_rd_data_vld,
  output logic [1:0]                state_dbg
);

  localparam int CH_WD = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Elaboration-time guard against unsupported configurations.
  if (NUM_CH < 1 || NUM_CH > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("rom_rd_arb: NUM_CH must be 1..8 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CH_WD-1:0]    rr_q, rr_d;
  logic [CH_WD-1:0]    gnt_q, gnt_d;
  logic [ADDR_WD-1:0]  addr_q, addr_d;
  logic [LEN_WD-1:0]   len_q, len_d;
  logic [LEN_WD-1:0]   beat_q, beat_d;
  logic [NUM_CH-1:0]   req_rdy_q, req_rdy_d;
  logic [NUM_CH-1:0]   rsp_vld_q, rsp_vld_d;
  logic [DATA_WD-1:0]  rsp_data_q, rsp_data_d;
  logic                rsp_last_q, rsp_last_d;
  logic                busy_q, busy_d;
  logic [ADDR_WD-1:0]  rom_addr_q, rom_addr_d;
  logic                ce_bar_q, ce_bar_d;
  logic                oe_bar_q, oe_bar_d;

`ifdef ROM_TIMEOUT_EN
  localparam int TO_WD = $clog2(TIMEOUT + 1);
  logic [TO_WD-1:0]    to_cnt_q, to_cnt_d;
  logic                rsp_err_q, rsp_err_d;
`endif

  // ---------------------------------------------------------------------------
  // Round-robin pick: first requester at or after rr_q, wrapping.
  // ---------------------------------------------------------------------------
  logic              arb_found;
  logic [CH_WD-1:0]  arb_idx;
  logic [CH_WD-1:0]  arb_cand;
  logic [CH_WD-1:0]  rr_next;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_cand  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      arb_cand = CH_WD'((int'(rr_q) + k) % NUM_CH);
      if (!arb_found && req_vld[arb_cand]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand;
      end
    end
  end

  assign rr_next = (int'(arb_idx) == NUM_CH - 1) ? '0 : arb_idx + CH_WD'(1);

  // ---------------------------------------------------------------------------
  // Next-state and output logic. All outputs are registered, so strobes and
  // responses appear the cycle after the state that decides them.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_d     = beat_q;
    req_rdy_d  = '0;
    rsp_vld_d  = '0;
    rsp_data_d = rsp_data_q;
    rsp_last_d = 1'b0;
    busy_d     = busy_q;
    rom_addr_d = rom_addr_q;
    ce_bar_d   = 1'b1;
    oe_bar_d   = 1'b1;
`ifdef ROM_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
    rsp_err_d  = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          req_rdy_d = NUM_CH'(1) << arb_idx;
          gnt_d     = arb_idx;
          addr_d    = req_addr[arb_idx*ADDR_WD +: ADDR_WD];
          len_d     = req_len[arb_idx*LEN_WD +: LEN_WD];
          beat_d    = '0;
          rr_d      = rr_next;
          busy_d    = 1'b1;
          state_d   = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        ce_bar_d   = 1'b0;
        oe_bar_d   = 1'b0;
        rom_addr_d = addr_q;
`ifdef ROM_TIMEOUT_EN
        to_cnt_d   = '0;
`endif
        state_d    = ST_WAIT;
      end

      ST_WAIT: begin
        if (rom_rd_data_vld) begin
          rsp_vld_d  = NUM_CH'(1) << gnt_q;
          rsp_data_d = rom_rd_data;
          rsp_last_d = (beat_q == len_q);
          if (beat_q == len_q) begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            // Burst address wraps at the end of the populated ROM, not at 2**ADDR_WD.
            addr_d  = (addr_q == ADDR_WD'(ROM_DEPTH - 1)) ? '0 : addr_q + ADDR_WD'(1);
            beat_d  = beat_q + LEN_WD'(1);
            state_d = ST_ISSUE;
          end
        end
`ifdef ROM_TIMEOUT_EN
        // to_cnt_q counts completed WAIT cycles of this beat; the abort
        // fires at the end of the TIMEOUT-th one.
        else if (to_cnt_q == TO_WD'(TIMEOUT - 1)) begin
          rsp_vld_d  = NUM_CH'(1) << gnt_q;
          rsp_data_d = '0;
          rsp_last_d = 1'b1;
          rsp_err_d  = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_WD'(1);
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      rr_q       <= '0;
      gnt_q      <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      req_rdy_q  <= '0;
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
      rsp_last_q <= 1'b0;
      busy_q     <= 1'b0;
      rom_addr_q <= '0;
      ce_bar_q   <= 1'b1;
      oe_bar_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      req_rdy_q  <= req_rdy_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      rsp_last_q <= rsp_last_d;
      busy_q     <= busy_d;
      rom_addr_q <= rom_addr_d;
      ce_bar_q   <= ce_bar_d;
      oe_bar_q   <= oe_bar_d;
    end
  end

`ifdef ROM_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign req_rdy     = req_rdy_q;
  assign rsp_vld     = rsp_vld_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_last    = rsp_last_q;
  assign busy        = busy_q;
  assign rom_rd_addr = rom_addr_q;
  assign CE_bar      = ce_bar_q;
  assign OE_bar      = oe_bar_q;
  assign WE_bar      = 1'b1;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_rom_rd_arb.sv
// -----------------------------------------------------------------------------
// tb_rom_rd_arb
// Directed bench for rom_rd_arb with a 21-word ROM whose word at address a is
// a ^ 8'h5A, returned one cycle after the strobe cycle.
// -----------------------------------------------------------------------------
module tb_rom_rd_arb;
  localparam int NUM_CH    = 2;
  localparam int ADDR_WD   = 8;
  localparam int DATA_WD   = 8;
  localparam int ROM_DEPTH = 21;
  localparam int LEN_WD    = 4;
  localparam int TIMEOUT   = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n = 1'b0;

  logic [NUM_CH-1:0]         req_vld  = '0;
  logic [NUM_CH*ADDR_WD-1:0] req_addr = '0;
  logic [NUM_CH*LEN_WD-1:0]  req_len  = '0;
  logic [NUM_CH-1:0]         req_rdy;
  logic [NUM_CH-1:0]         rsp_vld;
  logic [DATA_WD-1:0]        rsp_data;
  logic                      rsp_last;
  logic                      rsp_err;
  logic                      busy;
  logic [ADDR_WD-1:0]        rom_rd_addr;
  logic                      CE_bar, OE_bar, WE_bar;
  logic [DATA_WD-1:0]        rom_rd_data     = '0;
  logic                      rom_rd_data_vld = 1'b0;
  logic [1:0]                state_dbg;

  rom_rd_arb #(
    .NUM_CH(NUM_CH), .ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD),
    .ROM_DEPTH(ROM_DEPTH), .LEN_WD(LEN_WD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_vld(req_vld), .req_addr(req_addr), .req_len(req_len), .req_rdy(req_rdy),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .busy(busy), .rom_rd_addr(rom_rd_addr),
    .CE_bar(CE_bar), .OE_bar(OE_bar), .WE_bar(WE_bar),
    .rom_rd_data(rom_rd_data), .rom_rd_data_vld(rom_rd_data_vld),
    .state_dbg(state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  logic [1:0]  exp_gnt_q[$];
  logic [7:0]  exp_addr_q[$];
  logic [11:0] exp_rsp_q[$];   // {err, last, rsp_vld[1:0], data[7:0]}

  logic       rom_mute  = 1'b0;
  logic       pend      = 1'b0;
  logic [7:0] pend_addr = '0;
  logic       b2b_chk   = 1'b0;
  logic       to_chk    = 1'b0;
  int         prev_rsp_cyc    = -1;
  int         last_strobe_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- ROM model: data one cycle after the strobe cycle ----------
  always @(negedge clk) begin
    if (pend && !rom_mute) begin
      rom_rd_data_vld = 1'b1;
      rom_rd_data     = pend_addr ^ 8'h5A;
    end else begin
      rom_rd_data_vld = 1'b0;
      rom_rd_data     = '0;
    end
    pend      = !CE_bar && !OE_bar;
    pend_addr = rom_rd_addr;
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      if (req_rdy != '0) begin
        if (exp_gnt_q.size() == 0) check("gnt_unexpected", req_rdy, 0);
        else                       check("gnt", req_rdy, exp_gnt_q.pop_front());
        req_vld = req_vld & ~req_rdy;
      end
      if (!CE_bar) begin
        check("oe_with_ce", OE_bar, 0);
        if (exp_addr_q.size() == 0) check("strobe_unexpected", rom_rd_addr, 32'hFFFF);
        else                        check("strobe_addr", rom_rd_addr, exp_addr_q.pop_front());
        last_strobe_cyc = cyc;
      end
      if (rsp_vld != '0) begin
        if (exp_rsp_q.size() == 0) check("rsp_unexpected", {rsp_err, rsp_last, rsp_vld, rsp_data}, 0);
        else check("rsp", {rsp_err, rsp_last, rsp_vld, rsp_data}, exp_rsp_q.pop_front());
        check("busy_vs_last", busy, !rsp_last);
        if (b2b_chk) begin
          if (prev_rsp_cyc >= 0) check("b2b_spacing", cyc - prev_rsp_cyc, 3);
          prev_rsp_cyc = cyc;
        end
        if (to_chk) check("timeout_wait_cycles", cyc - last_strobe_cyc, 15);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic req(input int ch, input logic [7:0] a, input logic [3:0] l);
    req_addr[ch*ADDR_WD +: ADDR_WD] = a;
    req_len[ch*LEN_WD +: LEN_WD]    = l;
    req_vld[ch]                     = 1'b1;
  endtask

  task automatic exp_rsp(input logic [1:0] ch, input logic [7:0] d, input logic last);
    exp_rsp_q.push_back({1'b0, last, ch, d});
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while ((exp_rsp_q.size() != 0 || exp_gnt_q.size() != 0 || busy) && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, n < max, 1);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_rdy"},  req_rdy, 0);
    check({tag, "_rsp_vld"},  rsp_vld, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_last"}, rsp_last, 0);
    check({tag, "_rsp_err"},  rsp_err, 0);
    check({tag, "_busy"},     busy, 0);
    check({tag, "_rom_addr"}, rom_rd_addr, 0);
    check({tag, "_ce_bar"},   CE_bar, 1);
    check({tag, "_oe_bar"},   OE_bar, 1);
    check({tag, "_we_bar"},   WE_bar, 1);
    check({tag, "_state"},    state_dbg, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int seen;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    reset_n = 1'b1;
    @(negedge clk);

    // Single beat: ch0 @0x10, len 0.
    exp_gnt_q.push_back(2'b01);
    exp_addr_q.push_back(8'h10);
    exp_rsp(2'b01, 8'h4A, 1'b1);
    req(0, 8'h10, 4'd0);
    wait_done("single_done", 40);

    // Wrap: ch1 @19, len 3 -> 19, 20, 0, 1.
    exp_gnt_q.push_back(2'b10);
    exp_addr_q.push_back(8'd19); exp_addr_q.push_back(8'd20);
    exp_addr_q.push_back(8'd0);  exp_addr_q.push_back(8'd1);
    exp_rsp(2'b10, 8'h49, 1'b0);
    exp_rsp(2'b10, 8'h4E, 1'b0);
    exp_rsp(2'b10, 8'h5A, 1'b0);
    exp_rsp(2'b10, 8'h5B, 1'b1);
    req(1, 8'd19, 4'd3);
    wait_done("wrap_done", 60);

    // Reset in the middle of a 16-beat burst, after two beats.
    exp_gnt_q.push_back(2'b01);
    exp_addr_q.push_back(8'd5); exp_addr_q.push_back(8'd6);
    exp_rsp(2'b01, 8'h5F, 1'b0);
    exp_rsp(2'b01, 8'h5C, 1'b0);
    req(0, 8'd5, 4'd15);
    n = 0; seen = 0;
    while (seen < 2 && n < 100) begin
      @(posedge clk); #1;
      if (rsp_vld[0]) seen++;
      n++;
    end
    check("midburst_reached", seen, 2);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("midrst");
    repeat (3) @(negedge clk);
    check("midrst_rsp_left", exp_rsp_q.size(), 0);
    check("midrst_addr_left", exp_addr_q.size(), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Arbitration from reset: ch0 and ch1 together, ch0 re-requests at once.
    exp_gnt_q.push_back(2'b01); exp_gnt_q.push_back(2'b10); exp_gnt_q.push_back(2'b01);
    exp_addr_q.push_back(8'd2); exp_addr_q.push_back(8'd3);
    exp_addr_q.push_back(8'd8); exp_addr_q.push_back(8'd3);
    exp_rsp(2'b01, 8'h58, 1'b0);
    exp_rsp(2'b01, 8'h59, 1'b1);
    exp_rsp(2'b10, 8'h52, 1'b1);
    exp_rsp(2'b01, 8'h59, 1'b1);
    req(0, 8'd2, 4'd1);
    req(1, 8'd8, 4'd0);
    n = 0;
    while (!req_rdy[0] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("arb_first_grant_seen", req_rdy[0], 1);
    @(negedge clk); #1;
    req(0, 8'd3, 4'd0);
    wait_done("arb_done", 100);

    // Back-to-back: ch1 @0, len 15, 1-cycle ROM.
    b2b_chk = 1'b1;
    prev_rsp_cyc = -1;
    exp_gnt_q.push_back(2'b10);
    for (int i = 0; i < 16; i++) begin
      exp_addr_q.push_back(8'(i));
      exp_rsp(2'b10, 8'(i) ^ 8'h5A, i == 15);
    end
    req(1, 8'd0, 4'd15);
    wait_done("b2b_done", 200);
    b2b_chk = 1'b0;

    // ROM silent.
    rom_mute = 1'b1;
    exp_gnt_q.push_back(2'b01);
`ifdef ROM_TIMEOUT_EN
    exp_addr_q.push_back(8'd4);
    exp_rsp_q.push_back({1'b1, 1'b1, 2'b01, 8'h00});
    to_chk = 1'b1;
    req(0, 8'd4, 4'd2);
    wait_done("timeout_done", 100);
    to_chk = 1'b0;
    check("timeout_state_idle", state_dbg, 0);
    check("timeout_busy", busy, 0);
    rom_mute = 1'b0;
`else
    exp_addr_q.push_back(8'd4); exp_addr_q.push_back(8'd5); exp_addr_q.push_back(8'd6);
    exp_rsp(2'b01, 8'h5E, 1'b0);
    exp_rsp(2'b01, 8'h5F, 1'b0);
    exp_rsp(2'b01, 8'h5C, 1'b1);
    req(0, 8'd4, 4'd2);
    repeat (40) @(negedge clk);
    check("hold_busy", busy, 1);
    check("hold_state_wait", state_dbg, 2);
    check("hold_rsp_err", rsp_err, 0);
    check("hold_rsp_pending", exp_rsp_q.size(), 3);
    @(posedge clk);
    pend_addr = 8'd4;
    pend      = 1'b1;
    rom_mute  = 1'b0;
    wait_done("hold_done", 100);
`endif

    check("end_gnt_left", exp_gnt_q.size(), 0);
    check("end_addr_left", exp_addr_q.size(), 0);
    check("end_rsp_left", exp_rsp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
